prbs_framer: RTL and testbench

PRBS_FRAMER -- requirements
Module: prbs_framer

---
 rtl/comms_pkg.sv | 32 +++
 rtl/prbs_lfsr.sv | 27 ++
 rtl/prbs_framer.sv | 116 +++++++++++
 tb/tb_prbs_framer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comms_pkg.sv
// Shared definitions for the serial PRBS framing blocks: FSM state encoding,
// payload length constants and PRBS9 tap positions.
package comms_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREAMB  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam logic [8:0] LEN_64  = 9'd64;
  localparam logic [8:0] LEN_128 = 9'd128;
  localparam logic [8:0] LEN_256 = 9'd256;
  localparam logic [8:0] LEN_511 = 9'd511;

  // PRBS9, x^9 + x^5 + 1
  localparam int TAP_HI = 8;
  localparam int TAP_LO = 4;

  // Index of the last payload bit for a length select code
  function automatic logic [8:0] len_last(input logic [1:0] sel);
    logic [8:0] len;
    case (sel)
      2'b00:   len = LEN_64;
      2'b01:   len = LEN_128;
      2'b10:   len = LEN_256;
      default: len = LEN_511;
    endcase
    return len - 9'd1;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// PRBS9 Fibonacci LFSR: shifts toward the MSB, feedback enters at bit 0.
// load has priority over step so a frame restart can reseed on an emit edge.
module prbs_lfsr
  import comms_pkg::*;
#(
  parameter logic [8:0] SEED = 9'h1FF
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       load,
  input  logic [8:0] load_val,
  input  logic       step,
  output logic       msb
);

  logic [8:0] lfsr;

  // Seed on reset or load, advance one bit per step
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)  lfsr <= SEED;
    else if (load) lfsr <= load_val;
    else if (step) lfsr <= {lfsr[7:0], lfsr[TAP_HI] ^ lfsr[TAP_LO]};
  end

  assign msb = lfsr[TAP_HI];

endmodule

// File: rtl/prbs_framer.sv
// Serial frame generator: 8-bit preamble (MSB first) followed by a PRBS9
// payload of 64/128/256/511 bits, one bit per i_tick.
// Optional build macro PRBS_FRAMER_CNT_EN adds o_frame_cnt (completed frames).
module prbs_framer
  import comms_pkg::*;
#(
  parameter logic [8:0] SEED     = 9'h1FF,
  parameter logic [7:0] PREAMBLE = 8'hD5
) (
  input  logic        clock,
  input  logic        i_reset,
  input  logic        i_tick,
  input  logic        i_start,
  input  logic [1:0]  i_len_sel,
  output logic        o_bit,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_busy
`ifdef PRBS_FRAMER_CNT_EN
  ,
  output logic [15:0] o_frame_cnt
`endif
);

  state_t     state;
  logic [2:0] idx;
  logic [8:0] cnt;
  logic [8:0] len_q;     // last payload index of the current frame
  logic       lfsr_msb;
  logic       lfsr_load;
  logic       lfsr_step;
  logic       frame_end;

  // Frame boundaries: reseed on every frame start, step on payload ticks
  always_comb begin
    frame_end = (state == PAYLOAD) && i_tick && (cnt == len_q);
    lfsr_step = (state == PAYLOAD) && i_tick;
    lfsr_load = i_start && ((state == IDLE) || frame_end);
  end

  prbs_lfsr #(.SEED(SEED)) u_lfsr (
    .clock    (clock),
    .i_reset  (i_reset),
    .load     (lfsr_load),
    .load_val (SEED),
    .step     (lfsr_step),
    .msb      (lfsr_msb)
  );

  // Framing FSM with registered outputs; non-tick cycles only clear the strobes
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      idx     <= 3'd7;
      cnt     <= '0;
      len_q   <= LEN_64 - 9'd1;
      o_bit   <= 1'b0;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      case (state)
        IDLE: begin
          o_bit <= 1'b0;
          if (i_start) begin
            state  <= PREAMB;
            idx    <= 3'd7;
            len_q  <= len_last(i_len_sel);
            o_busy <= 1'b1;
          end
        end
        PREAMB: if (i_tick) begin
          o_bit   <= PREAMBLE[idx];
          o_valid <= 1'b1;
          o_sof   <= (idx == 3'd7);
          idx     <= idx - 3'd1;
          if (idx == 3'd0) begin
            state <= PAYLOAD;
            cnt   <= '0;
          end
        end
        PAYLOAD: if (i_tick) begin
          o_bit   <= lfsr_msb;
          o_valid <= 1'b1;
          cnt     <= cnt + 9'd1;
          if (cnt == len_q) begin
            cnt <= '0;
            if (i_start) begin
              state <= PREAMB;
              idx   <= 3'd7;
              len_q <= len_last(i_len_sel);
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef PRBS_FRAMER_CNT_EN
  // Completed-frame counter, bumps on the edge emitting the last payload bit
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)       o_frame_cnt <= '0;
    else if (frame_end) o_frame_cnt <= o_frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_prbs_framer.sv
// Self-checking bench for prbs_framer. Expected streams come from a frame
// model: preamble constant followed by the PRBS9 recurrence
// b[k] = b[k-9] ^ b[k-5] with b[0..8] taken from the seed MSB first.
// Build with PRBS_FRAMER_CNT_EN to also exercise o_frame_cnt.
module tb_prbs_framer;

  localparam logic [8:0] SEED = 9'h1FF;
  localparam logic [7:0] PRE  = 8'hD5;

  logic       clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick = 1'b0;
  logic       i_start = 1'b0;
  logic [1:0] i_len_sel = 2'b00;
  logic       o_bit, o_valid, o_sof, o_busy;
`ifdef PRBS_FRAMER_CNT_EN
  logic [15:0] o_frame_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit cap_bit[$], cap_sof[$], exp_bit[$], exp_sof[$];

  always #5 clock = ~clock;

  prbs_framer #(.SEED(SEED), .PREAMBLE(PRE)) dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_tick    (i_tick),
    .i_start   (i_start),
    .i_len_sel (i_len_sel),
    .o_bit     (o_bit),
    .o_valid   (o_valid),
    .o_sof     (o_sof),
    .o_busy    (o_busy)
`ifdef PRBS_FRAMER_CNT_EN
    ,
    .o_frame_cnt (o_frame_cnt)
`endif
  );

  // Capture every emitted bit away from the active edge
  always @(negedge clock) if (o_valid === 1'b1) begin
    cap_bit.push_back(o_bit);
    cap_sof.push_back(o_sof);
  end

  function automatic int len_of(input logic [1:0] s);
    case (s)
      2'b00:   return 64;
      2'b01:   return 128;
      2'b10:   return 256;
      default: return 511;
    endcase
  endfunction

  task automatic add_frame(input logic [1:0] s);
    bit p[$];
    bit b;
    for (int i = 0; i < 8; i++) begin
      exp_bit.push_back(PRE[7-i]);
      exp_sof.push_back(i == 0);
    end
    for (int k = 0; k < len_of(s); k++) begin
      if (k < 9) b = SEED[8-k];
      else       b = p[k-9] ^ p[k-5];
      p.push_back(b);
      exp_bit.push_back(b);
      exp_sof.push_back(1'b0);
    end
  endtask

  // Number of positions where captured bit/sof differ from expectation
  function automatic int qdiff();
    int d = 0;
    for (int i = 0; i < exp_bit.size() && i < cap_bit.size(); i++)
      if (cap_bit[i] !== exp_bit[i] || cap_sof[i] !== exp_sof[i]) d++;
    return d;
  endfunction

  task automatic clear_q();
    cap_bit.delete(); cap_sof.delete(); exp_bit.delete(); exp_sof.delete();
  endtask

  task automatic cyc(input logic t);
    i_tick = t;
    @(posedge clock);
    #1 i_tick = 1'b0;
  endtask

  task automatic ticks(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap, 0)) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b0; i_start = 1'b0; i_tick = 1'b0;
    repeat (2) @(posedge clock);
    #1 i_reset = 1'b1;
    @(posedge clock);
    #1 clear_q();
  endtask

  // Tick until the frame finishes; an exhausted budget is a failure
  task automatic drain(input int maxgap);
    int b = 0;
    while (o_busy === 1'b1 && b < 2000) begin ticks(1, maxgap); b++; end
    cyc(1'b0);
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_err++; $display("FAIL drain: o_busy=%b, required 0 within 2000 ticks", o_busy);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_start = 1'b1; i_len_sel = 2'b00;
    repeat (3) cyc(1'b1);
    n_cmp++; if (o_bit   !== 1'b0) begin n_err++; $display("FAIL reset o_bit: got %b want 0", o_bit); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset o_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_sof   !== 1'b0) begin n_err++; $display("FAIL reset o_sof: got %b want 0", o_sof); end
    n_cmp++; if (o_busy  !== 1'b0) begin n_err++; $display("FAIL reset o_busy: got %b want 0", o_busy); end
    i_start = 1'b0;
    #1 i_reset = 1'b1;
    ticks(4, 0);
    n_cmp++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || cap_bit.size() != 0) begin
      n_err++; $display("FAIL idle_ticks: valid=%b busy=%b bits=%0d want 0/0/0", o_valid, o_busy, cap_bit.size());
    end
  endtask

  task automatic test_basic();
    do_reset();
    i_len_sel = 2'b00; i_start = 1'b1;
    cyc(1'b0);
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b want 1", o_busy); end
    repeat (9) cyc(1'b0);
    cyc(1'b1);
    n_cmp++; if ({o_valid, o_sof, o_bit} !== 3'b111) begin
      n_err++; $display("FAIL first_bit: valid/sof/bit=%b%b%b want 111", o_valid, o_sof, o_bit);
    end
    cyc(1'b0);
    n_cmp++; if ({o_valid, o_sof} !== 2'b00) begin
      n_err++; $display("FAIL pulse_width: valid/sof=%b%b want 00", o_valid, o_sof);
    end
    i_start = 1'b0;
    for (int i = 0; i < 71; i++) begin repeat (9) cyc(1'b0); cyc(1'b1); end
    repeat (9) cyc(1'b0);
    n_cmp++; if (o_busy !== 1'b0 || o_bit !== 1'b0) begin
      n_err++; $display("FAIL basic_idle: busy=%b bit=%b want 0/0", o_busy, o_bit);
    end
    ticks(5, 0);
    add_frame(2'b00);
    n_cmp++; if (cap_bit.size() != 72) begin n_err++; $display("FAIL basic_count: got %0d want 72", cap_bit.size()); end
    n_cmp++; if (qdiff() != 0) begin n_err++; $display("FAIL basic_bits: %0d positions differ, want 0", qdiff()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_len_sel = 2'b11; i_start = 1'b1;
    cyc(1'b0);
    ticks(2 * 519 + 10, 0);
    i_start = 1'b0;
    drain(0);
    repeat (3) add_frame(2'b11);
    n_cmp++; if (cap_bit.size() != exp_bit.size()) begin
      n_err++; $display("FAIL b2b_count: got %0d want %0d", cap_bit.size(), exp_bit.size());
    end
    n_cmp++; if (qdiff() != 0) begin n_err++; $display("FAIL b2b_bits: %0d positions differ, want 0", qdiff()); end
  endtask

  task automatic test_stop_mid();
    int nv = 28;
    int b = 0;
    do_reset();
    i_len_sel = 2'b00; i_start = 1'b1;
    cyc(1'b0);
    ticks(28, 1);
    i_start = 1'b0;
    while (nv < 72 && b < 1000) begin
      cyc(1'($urandom_range(1, 0)));
      if (o_valid === 1'b1) nv++;
      b++;
    end
    n_cmp++; if (nv != 72) begin n_err++; $display("FAIL stop_valids: got %0d want 72", nv); end
    cyc(1'b0);
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b want 0", o_busy); end
    ticks(5, 0);
    add_frame(2'b00);
    n_cmp++; if (cap_bit.size() != 72) begin n_err++; $display("FAIL stop_count: got %0d want 72", cap_bit.size()); end
    n_cmp++; if (qdiff() != 0) begin n_err++; $display("FAIL stop_bits: %0d positions differ, want 0", qdiff()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_len_sel = 2'b01; i_start = 1'b1;
    cyc(1'b0);
    ticks(38, 1);
    i_tick = 1'b1;
    #2 i_reset = 1'b0;
    #1;
    n_cmp++; if ({o_valid, o_sof, o_bit, o_busy} !== 4'b0000) begin
      n_err++; $display("FAIL async_reset: valid/sof/bit/busy=%b%b%b%b want 0000", o_valid, o_sof, o_bit, o_busy);
    end
    i_tick = 1'b0;
    clear_q();
    repeat (2) @(posedge clock);
    @(negedge clock) i_reset = 1'b1;
    cyc(1'b0);
    ticks(30, 1);
    i_start = 1'b0;
    drain(1);
    add_frame(2'b01);
    n_cmp++; if (cap_bit.size() != 136) begin n_err++; $display("FAIL rmid_count: got %0d want 136", cap_bit.size()); end
    n_cmp++; if (qdiff() != 0) begin n_err++; $display("FAIL rmid_bits: %0d positions differ, want 0", qdiff()); end
  endtask

  task automatic test_len_change();
    do_reset();
    i_len_sel = 2'b00; i_start = 1'b1;
    cyc(1'b0);
    ticks(10, 1);
    i_len_sel = 2'b10;
    ticks(67, 1);
    i_start = 1'b0;
    i_len_sel = 2'b01;
    drain(1);
    add_frame(2'b00);
    add_frame(2'b10);
    n_cmp++; if (cap_bit.size() != 336) begin n_err++; $display("FAIL len_count: got %0d want 336", cap_bit.size()); end
    n_cmp++; if (qdiff() != 0) begin n_err++; $display("FAIL len_bits: %0d positions differ, want 0", qdiff()); end
  endtask

  task automatic test_random();
    logic [1:0] s;
    int k;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      s = 2'($urandom_range(2, 0));
      k = $urandom_range(2, 1);
      i_len_sel = s; i_start = 1'b1;
      cyc(1'b0);
      ticks((k - 1) * (8 + len_of(s)) + 3, 2);
      i_start = 1'b0;
      i_len_sel = 2'($urandom);
      drain(2);
      repeat (k) add_frame(s);
      n_cmp++; if (cap_bit.size() != exp_bit.size()) begin
        n_err++; $display("FAIL rand%0d_count: got %0d want %0d", it, cap_bit.size(), exp_bit.size());
      end
      n_cmp++; if (qdiff() != 0) begin n_err++; $display("FAIL rand%0d_bits: %0d positions differ, want 0", it, qdiff()); end
    end
  endtask

`ifdef PRBS_FRAMER_CNT_EN
  task automatic test_frame_cnt();
    do_reset();
    n_cmp++; if (o_frame_cnt !== 16'd0) begin n_err++; $display("FAIL cnt_reset: got %0d want 0", o_frame_cnt); end
    i_len_sel = 2'b00; i_start = 1'b1;
    cyc(1'b0);
    ticks(3 * 72 - 5, 0);
    i_start = 1'b0;
    drain(0);
    n_cmp++; if (o_frame_cnt !== 16'd3) begin n_err++; $display("FAIL cnt_three: got %0d want 3", o_frame_cnt); end
    force dut.o_frame_cnt = 16'hFFFF;
    @(posedge clock);
    #1 release dut.o_frame_cnt;
    i_start = 1'b1;
    cyc(1'b0);
    ticks(3, 0);
    i_start = 1'b0;
    drain(0);
    n_cmp++; if (o_frame_cnt !== 16'd0) begin n_err++; $display("FAIL cnt_wrap: got %0d want 0", o_frame_cnt); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stop_mid();
    test_reset_mid();
    test_len_change();
    test_random();
`ifdef PRBS_FRAMER_CNT_EN
    test_frame_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
